// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, oversampling constants and parity helper shared by the UART RX and TX stages
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK = 7;
   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;
   function automatic logic exp_parity(input logic [7:0] d, input logic eps, input logic stk);
      return stk ? ~eps : (eps ? ^d : ~^d);
   endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line, resets to the idle-high level
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_sync
);
   logic meta;
   // shift the line through two flops; reset to 1 so a reset never looks like a start bit
   always_ff @(posedge clk)
      if (!rst) {rx_sync, meta} <= 2'b11;
      else {rx_sync, meta} <= {meta, rx};
endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: 16x oversampled UART receiver with parity, framing and break detection
module uart_rx_top (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic [1:0] wls,
   output logic       push,
   output logic [7:0] dout,
   output logic       pe,
   output logic       fe,
   output logic       bi
);
   import uart_pkg::*;
   rx_state_t  state;
   logic       rxs;
   logic [3:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
   logic       pen_q, eps_q, stk_q;
   logic [1:0] wls_q;
   logic       perr, zero, full, last;
   uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_sync(rxs));
   assign full = cnt == 4'(OVERSAMPLE - 1);
   assign last = idx == 3'd4 + {1'b0, wls_q};
   // frame FSM: the tick counter free-wraps every 16 baud pulses, so each wrap lands on a bit centre
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         pen_q <= 1'b0;
         eps_q <= 1'b0;
         stk_q <= 1'b0;
         wls_q <= WLS_5;
         perr  <= 1'b0;
         zero  <= 1'b0;
         push  <= 1'b0;
         dout  <= '0;
         pe    <= 1'b0;
         fe    <= 1'b0;
         bi    <= 1'b0;
      end else begin
         push <= 1'b0;
         if (baud_pulse) begin
            cnt <= cnt + 4'd1;
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (!rxs) state <= START;
               end
               START: if (cnt == 4'(MID_TICK)) begin
                  cnt <= '0;
                  state <= rxs ? IDLE : DATA;
                  pen_q <= pen;
                  eps_q <= eps;
                  stk_q <= sticky_parity;
                  wls_q <= wls;
                  idx   <= '0;
                  shift <= '0;
                  perr  <= 1'b0;
                  zero  <= 1'b1;
               end
               DATA: if (full) begin
                  shift[idx] <= rxs;
                  zero <= zero & ~rxs;
                  idx  <= idx + 3'd1;
                  if (last) state <= pen_q ? PARITY : STOP;
               end
               PARITY: if (full) begin
                  perr  <= rxs != exp_parity(shift, eps_q, stk_q);
                  zero  <= zero & ~rxs;
                  state <= STOP;
               end
               STOP: if (full) begin
                  push  <= 1'b1;
                  dout  <= shift;
                  pe    <= perr;
                  fe    <= ~rxs;
                  bi    <= zero & ~rxs;
                  state <= rxs ? IDLE : WAIT_HIGH;
               end
               WAIT_HIGH: if (rxs) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed bit-banged frames against uart_rx_top with hand-computed results
module tb_uart_rx_top;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       baud_pulse = 1'b0;
   logic       rx = 1'b1;
   logic       pen = 1'b0;
   logic       eps = 1'b0;
   logic       sticky_parity = 1'b0;
   logic [1:0] wls = 2'b11;
   logic       push;
   logic [7:0] dout;
   logic       pe, fe, bi;
   int         tests = 0;
   int         fails = 0;
   logic [10:0] rxq[$];
   logic       push_d = 1'b0;
   logic       wide = 1'b0;

   uart_rx_top dut (
      .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx),
      .pen(pen), .eps(eps), .sticky_parity(sticky_parity), .wls(wls),
      .push(push), .dout(dout), .pe(pe), .fe(fe), .bi(bi)
   );

   always #5 clk = ~clk;

   // baud tick: one clk high every 6 clks
   initial forever begin
      repeat (5) @(negedge clk);
      baud_pulse = 1'b1;
      @(negedge clk);
      baud_pulse = 1'b0;
   end

   // capture every received character as {bi, fe, pe, dout} and flag any push wider than one clk
   always @(negedge clk) begin
      if (push) rxq.push_back({bi, fe, pe, dout});
      wide   <= wide | (push & push_d);
      push_d <= push;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic v, input int nbits);
      rx = v;
      repeat (nbits * 96) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input int nb, input logic par_en, input logic par,
                       input logic stopb, input logic chg);
      logic [1:0] wls_s;
      logic       pen_s;
      wls_s = wls;
      pen_s = pen;
      hold(1'b0, 1);
      if (chg) begin
         wls = ~wls;
         pen = ~pen;
      end
      for (int i = 0; i < nb; i++) hold(d[i], 1);
      if (par_en) hold(par, 1);
      hold(stopb, 1);
      rx = 1'b1;
      wls = wls_s;
      pen = pen_s;
   endtask

   task automatic frame(input string tag, input logic [10:0] exp, input int n);
      logic [10:0] g;
      check({tag, "_count"}, rxq.size(), n);
      g = (rxq.size() > 0) ? rxq.pop_front() : 11'h7ff;
      check(tag, g, exp);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check("rst_push", push, 0);
      check("rst_dout", dout, 0);
      check("rst_pe", pe, 0);
      check("rst_fe", fe, 0);
      check("rst_bi", bi, 0);
      rst = 1'b1;
      hold(1'b1, 2);
      pen = 1'b1; eps = 1'b1; wls = 2'b11;
      send(8'h13, 8, 1, 1, 1, 0); hold(1'b1, 1);
      frame("good", {3'b000, 8'h13}, 1);
      send(8'h13, 8, 1, 0, 1, 0); hold(1'b1, 1);
      frame("parity_err", {3'b001, 8'h13}, 1);
      send(8'h13, 8, 1, 1, 0, 0); hold(1'b1, 1);
      frame("frame_err", {3'b010, 8'h13}, 1);
      hold(1'b0, 20);
      frame("break", {3'b110, 8'h00}, 1);
      hold(1'b1, 3);
      check("break_no_repeat", rxq.size(), 0);
      check("break_dout_hold", dout, 8'h00);
      send(8'h13, 8, 1, 1, 1, 0); hold(1'b1, 1);
      frame("after_break", {3'b000, 8'h13}, 1);
      rx = 1'b0;
      repeat (24) @(negedge clk);
      hold(1'b1, 2);
      check("glitch", rxq.size(), 0);
      eps = 1'b0; sticky_parity = 1'b1;
      send(8'h13, 8, 1, 1, 1, 0); hold(1'b1, 1);
      frame("sticky", {3'b000, 8'h13}, 1);
      sticky_parity = 1'b0;
      send(8'h13, 8, 1, 0, 1, 0); hold(1'b1, 1);
      frame("odd", {3'b000, 8'h13}, 1);
      pen = 1'b0; wls = 2'b00;
      send(8'h15, 5, 0, 0, 1, 0); hold(1'b1, 1);
      frame("wls5", {3'b000, 8'h15}, 1);
      wls = 2'b11;
      send(8'hA5, 8, 0, 0, 1, 0);
      send(8'h3C, 8, 0, 0, 1, 0); hold(1'b1, 1);
      frame("b2b_first", {3'b000, 8'hA5}, 2);
      frame("b2b_second", {3'b000, 8'h3C}, 1);
      hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_dout", dout, 8'h00);
      rx = 1'b1;
      rst = 1'b1;
      hold(1'b1, 3);
      check("midrst_no_push", rxq.size(), 0);
      send(8'h5A, 8, 0, 0, 1, 1); hold(1'b1, 1);
      frame("cfg_held", {3'b000, 8'h5A}, 1);
      check("push_width", wide, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_top.md
UART_RX_TOP -- requirements
Module: uart_rx_top

Interface
REQ-001 SHALL have: clk  input  1  system clock; all logic on posedge clk.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: baud_pulse  input  1  one-clk tick at 16x bit rate; the same tick that drives the TX stage.
REQ-004 SHALL have: rx  input  1  serial line (idle high), asynchronous to clk.
REQ-005 SHALL have: pen, eps, sticky_parity  input  1 each  parity enable, even-parity select, stick parity (LCR semantics shared with TX).
REQ-006 SHALL have: wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 SHALL have: push  output  1  one-clk pulse; received character ready for RX FIFO.
REQ-008 SHALL have: dout  output  8  received data, LSB first on line, right-justified, upper bits zero.
REQ-009 SHALL have: pe, fe, bi  output  1 each  parity error, framing error, break indication for the character in dout.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; a 4-bit tick counter advances only on baud_pulse.
REQ-012 IDLE: on a baud_pulse with synced rx=0, SHALL go to START with counter=0.
REQ-013 START: at tick 7 (mid-bit) SHALL go to DATA if rx=0, else return to IDLE (glitch rejection, no push).
REQ-014 DATA: SHALL sample one bit every 16 ticks at mid-bit, shifting LSB first; after 5+wls bits go to PARITY if pen=1, else STOP.
REQ-015 PARITY: SHALL sample one bit at mid-bit; expected value = ~eps when sticky_parity=1, else ^data when eps=1, else ~^data; mismatch sets pe.
REQ-016 STOP: SHALL sample exactly one stop bit at mid-bit regardless of TX stop-length setting; stop=0 sets fe.
REQ-017 bi SHALL be 1 when all data bits, the parity bit (if enabled) and the stop bit sampled 0.
REQ-018 push SHALL assert for exactly one clk, the cycle after the stop-bit sampling baud_pulse; dout/pe/fe/bi SHALL update in that same cycle and hold until the next push.
REQ-019 After STOP: rx=1 -> IDLE; rx=0 -> WAIT_HIGH, which SHALL stay until a baud_pulse sees rx=1, then IDLE (no further push during a held break).
REQ-020 pen/eps/sticky_parity/wls SHALL be sampled only at START exit and held for the frame; changes mid-frame SHALL not affect that frame.
REQ-021 A new start bit immediately after a valid stop SHALL be accepted without a lost tick (back-to-back frames).

Reset
REQ-022 With rst=0 at a posedge: state=IDLE, counter=0, shift register=0, push=0, dout=8'h00, pe=fe=bi=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL abandon the frame with no push; reception resumes at the next start bit after rst=1.

Structure
REQ-024 Package uart_pkg SHALL hold the rx_state_t enum, OVERSAMPLE=16, MID_TICK=7, and wls encoding constants (shared with TX).
REQ-025 Synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset-to-1); all other logic in uart_rx_top.

Verification (baud_pulse every 6 clk, fed by the TX stage or a bit-banged model)
REQ-026 wls=11, pen=1, eps=1, frame 0x13 with parity bit 1, stop 1 -> one push, dout=8'h13, pe=0, fe=0, bi=0.
REQ-027 Same frame with parity bit 0 -> push, dout=8'h13, pe=1; stop bit 0 instead -> push, fe=1.
REQ-028 rx held low 20 bit-times -> exactly one push, dout=8'h00, bi=1, fe=1; next push only after rx high and a fresh frame.
REQ-029 rx low for 4 ticks then high -> no push, state returns IDLE.
REQ-030 wls=00, pen=0, data 0x15 -> dout=8'h15; two frames back-to-back 0xA5, 0x3C (wls=11) -> two pushes, correct order.
REQ-031 rst driven 0 during DATA of a frame -> no push; following clean frame 0x5A received correctly.
